// File: rtl/jailbreak_lpf_scheduler.sv
// rtl/jailbreak_lpf_scheduler.sv - two-channel first-order IIR low-pass sharing one 18x18 multiplier
module jailbreak_lpf_scheduler #(
    parameter int DIV    = 256,
    parameter int B1_DEF = 352,
    parameter int B2_DEF = 352,
    parameter int A2_DEF = -32064
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] in0,
    input  logic signed [15:0] in1,
    input  logic               cfg_we,
    input  logic               cfg_ch,
    input  logic [1:0]         cfg_sel,
    input  logic signed [17:0] cfg_data,
    output logic signed [15:0] out0,
    output logic signed [15:0] out1,
    output logic [1:0]         out_valid,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, MAC_B1, MAC_B2, MAC_A2, WB} state_t;

    logic [9:0]         cnt;
    logic               tick;
    state_t             state, state_nxt;
    logic               ch, ch_nxt;
    logic signed [17:0] sh_coef  [2][3];
    logic signed [17:0] sh_nxt   [2][3];
    logic signed [17:0] act_coef [2][3];
    logic signed [15:0] x_smp    [2];
    logic signed [15:0] x_prev   [2];
    logic signed [15:0] y_prev   [2];
    logic signed [37:0] acc;
    logic signed [17:0] mul_a, mul_b;
    logic signed [35:0] product;
    logic signed [37:0] y_full;
    logic signed [15:0] y_sat;

    function automatic logic signed [17:0] coef_def(input int k);
        case (k)
            0:       return 18'(B1_DEF);
            1:       return 18'(B2_DEF);
            default: return 18'(A2_DEF);
        endcase
    endfunction

    assign tick = (cnt == 10'(DIV - 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset || tick) cnt <= '0;
        else                cnt <= cnt + 10'd1;
    end

    // Shadow-next view so a write landing on the tick edge reaches the active set too.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) begin
                sh_nxt[c][k] = sh_coef[c][k];
                if (cfg_we && int'(cfg_ch) == c && int'(cfg_sel) == k)
                    sh_nxt[c][k] = cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!reset) begin
                    sh_coef[c][k]  <= coef_def(k);
                    act_coef[c][k] <= coef_def(k);
                end else begin
                    sh_coef[c][k] <= sh_nxt[c][k];
                    if (tick) act_coef[c][k] <= sh_nxt[c][k];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = MAC_B1;
                    ch_nxt    = 1'b0;
                end
            end
            MAC_B1: begin
                state_nxt = MAC_B2;
                mul_a     = act_coef[ch][0];
                mul_b     = 18'(x_smp[ch]);
            end
            MAC_B2: begin
                state_nxt = MAC_A2;
                mul_a     = act_coef[ch][1];
                mul_b     = 18'(x_prev[ch]);
            end
            MAC_A2: begin
                state_nxt = WB;
                mul_a     = act_coef[ch][2];
                mul_b     = 18'(y_prev[ch]);
            end
            WB: begin
                if (ch) begin
                    state_nxt = IDLE;
                    ch_nxt    = 1'b0;
                end else begin
                    state_nxt = MAC_B1;
                    ch_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign product = mul_a * mul_b;
    assign y_full  = acc >>> 15;

    always_comb begin
        y_sat = y_full[15:0];
        if (y_full > 38'sd32767)       y_sat = 16'sh7fff;
        else if (y_full < -38'sd32768) y_sat = 16'sh8000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ch        <= 1'b0;
            acc       <= '0;
            out0      <= '0;
            out1      <= '0;
            out_valid <= '0;
            for (int c = 0; c < 2; c++) begin
                x_smp[c]  <= '0;
                x_prev[c] <= '0;
                y_prev[c] <= '0;
            end
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            out_valid <= '0;
            if (tick) begin
                x_smp[0] <= in0;
                x_smp[1] <= in1;
            end
            case (state)
                MAC_B1: acc <= 38'(product);
                MAC_B2: acc <= acc + 38'(product);
                MAC_A2: acc <= acc - 38'(product);
                WB: begin
                    out_valid[ch] <= 1'b1;
                    y_prev[ch]    <= y_sat;
                    x_prev[ch]    <= x_smp[ch];
                    if (ch) out1 <= y_sat;
                    else    out0 <= y_sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jailbreak_lpf_scheduler.sv
// tb/tb_jailbreak_lpf_scheduler.sv - scoreboard bench for jailbreak_lpf_scheduler
module tb_jailbreak_lpf_scheduler;

    localparam int DIV = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] in0, in1;
    logic               cfg_we, cfg_ch;
    logic [1:0]         cfg_sel;
    logic signed [17:0] cfg_data;
    logic signed [15:0] out0, out1;
    logic [1:0]         out_valid;
    logic               busy;

    jailbreak_lpf_scheduler #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .out0(out0), .out1(out1), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     n_vec = 0, n_bad = 0;
    int     cyc = 0, mcnt = 0, tick_cnt = 0, last_tick = -100;
    int     h0 = 0, h1 = 0;
    bit     reset_seen = 1'b0;
    int     m_sh[2][3];
    int     m_act[2][3];
    longint m_xp[2];
    longint m_yp[2];

    task automatic check(input string name, input longint got, input longint want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Behavioural filter: y = sat((B1*x + B2*x_prev - A2*y_prev) >>> 15), issued on each tick edge.
    always @(posedge clk) begin
        longint acc;
        int     x, y;
        exp_t   e;
        cyc++;
        if (!reset) begin
            reset_seen = 1'b1;
            mcnt       = 0;
            last_tick  = -100;
            h0         = 0;
            h1         = 0;
            q0.delete();
            q1.delete();
            for (int c = 0; c < 2; c++) begin
                m_sh[c][0] = 352;
                m_sh[c][1] = 352;
                m_sh[c][2] = -32064;
                m_xp[c]    = 0;
                m_yp[c]    = 0;
            end
            m_act = m_sh;
        end else begin
            if (cfg_we && cfg_sel != 2'd3) m_sh[int'(cfg_ch)][int'(cfg_sel)] = int'(cfg_data);
            if (mcnt == DIV - 1) begin
                mcnt  = 0;
                m_act = m_sh;
                for (int c = 0; c < 2; c++) begin
                    x   = (c == 0) ? int'(in0) : int'(in1);
                    acc = longint'(m_act[c][0]) * x + longint'(m_act[c][1]) * m_xp[c]
                        - longint'(m_act[c][2]) * m_yp[c];
                    y   = sat16(acc >>> 15);
                    e.val = y;
                    e.cyc = cyc + 4 * (c + 1);
                    if (c == 0) q0.push_back(e);
                    else        q1.push_back(e);
                    m_xp[c] = x;
                    m_yp[c] = y;
                end
                last_tick = cyc;
                tick_cnt++;
            end else begin
                mcnt++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   v0, v1;
        if (reset_seen) begin
            while (q0.size() > 0 && q0[0].cyc < cyc) e = q0.pop_front();
            while (q1.size() > 0 && q1[0].cyc < cyc) e = q1.pop_front();
            v0 = (q0.size() > 0 && q0[0].cyc == cyc);
            v1 = (q1.size() > 0 && q1[0].cyc == cyc);
            if (v0) begin e = q0.pop_front(); h0 = e.val; end
            if (v1) begin e = q1.pop_front(); h1 = e.val; end
            check("out_valid0", out_valid[0], v0);
            check("out_valid1", out_valid[1], v1);
            check("out0", out0, h0);
            check("out1", out1, h1);
            check("busy", busy, (cyc - last_tick) <= 7);
        end
    end

    task automatic wait_ticks(input int n);
        int target = tick_cnt + n;
        for (int i = 0; i < (n + 1) * DIV && tick_cnt < target; i++) @(negedge clk);
    endtask

    task automatic cfg_write(input logic c, input logic [1:0] s, input int d);
        cfg_we   = 1'b1;
        cfg_ch   = c;
        cfg_sel  = s;
        cfg_data = 18'(d);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in0 = 16'sd16384; in1 = 16'sd0;
        cfg_we = 1'b0; cfg_ch = 1'b0; cfg_sel = 2'd0; cfg_data = '0;
        repeat (3) @(negedge clk);
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        wait_ticks(1);
        repeat (4) @(negedge clk);
        check("first_out0", out0, 176);
        check("first_valid", out_valid, 2'b01);
        repeat (4) @(negedge clk);
        check("first_valid1", out_valid, 2'b10);
        check("first_out1", out1, 0);
        wait_ticks(1);
        repeat (4) @(negedge clk);
        check("second_out0", out0, 524);
        for (int i = 0; i < 20; i++) begin
            wait_ticks(1);
            repeat (4) @(negedge clk);
            check("no_overshoot", out0 <= 16384, 1);
        end

        cfg_write(1'b1, 2'd0, 32767);
        cfg_write(1'b1, 2'd1, 32767);
        cfg_write(1'b0, 2'd3, 0);
        in1 = 16'sd32767;
        wait_ticks(2);
        repeat (8) @(negedge clk);
        check("sat_pos_out1", out1, 32767);
        in1 = -16'sd32768;
        wait_ticks(2);
        repeat (8) @(negedge clk);
        check("sat_neg_out1", out1, -32768);

        wait_ticks(1);
        check("busy_at_write", busy, 1);
        cfg_write(1'b0, 2'd0, 0);
        cfg_write(1'b1, 2'd0, 1000);
        wait_ticks(2);

        for (int i = 0; i < 2 * DIV && mcnt != DIV - 1; i++) @(negedge clk);
        cfg_write(1'b0, 2'd0, 20000);
        wait_ticks(2);

        wait_ticks(1);
        repeat (5) @(negedge clk);
        check("abort_busy", busy, 1);
        reset = 1'b0;
        in0 = -16'sd1;
        in1 = 16'sd1;
        repeat (2) @(negedge clk);
        check("abort_out0", out0, 0);
        check("abort_out1", out1, 0);
        check("abort_valid", out_valid, 0);
        reset = 1'b1;

        wait_ticks(100);
        repeat (8) @(negedge clk);
        check("settle_out0", out0, -1);
        check("settle_out1", out1, 0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jailbreak_lpf_scheduler.md
JAILBREAK_LPF_SCHEDULER -- requirements
Module: jailbreak_lpf_scheduler

Interface
REQ-001 Parameter DIV, default 256: clocks per sample period (49.152 MHz / 256 = 192 kHz); legal range 16..1023.
REQ-002 Parameter B1_DEF, default 352: reset value of both channels' B1 coefficient (Q15).
REQ-003 Parameter B2_DEF, default 352: reset value of both channels' B2 coefficient (Q15).
REQ-004 Parameter A2_DEF, default -32064: reset value of both channels' A2 coefficient (Q15).
REQ-005 clk  in  1  single system clock; all logic is rising-edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 in0  in  16  signed audio, channel 0 (speech).
REQ-008 in1  in  16  signed audio, channel 1 (PSG).
REQ-009 cfg_we  in  1  coefficient write strobe, one clock.
REQ-010 cfg_ch  in  1  target channel of a coefficient write.
REQ-011 cfg_sel  in  2  coefficient select: 0=B1, 1=B2, 2=A2, 3=ignored.
REQ-012 cfg_data  in  18  signed Q15 coefficient value.
REQ-013 out0  out  16  signed filtered channel 0.
REQ-014 out1  out  16  signed filtered channel 1.
REQ-015 out_valid  out  2  one-clock update strobe per channel (bit n = channel n).
REQ-016 busy  out  1  high while the filter FSM is outside IDLE.

Function
REQ-017 A free-running counter SHALL count 0..DIV-1 and wrap; tick SHALL be asserted in the cycle the counter equals DIV-1.
REQ-018 On tick, the block SHALL capture in0/in1 into sample registers and copy the shadow coefficients into the active coefficients.
REQ-019 A cfg_we write SHALL update only the shadow coefficient selected by cfg_ch/cfg_sel; active coefficients SHALL change only on tick.
REQ-020 A write coinciding with tick SHALL be in effect for that tick's computation.
REQ-021 One signed 18x18 multiplier SHALL be shared by both channels; no other multipliers are permitted.
REQ-022 FSM states: IDLE, MAC_B1, MAC_B2, MAC_A2, WB; a channel index selects operands.
REQ-023 IDLE -> MAC_B1 (channel 0) on tick; MAC_B1 -> MAC_B2 -> MAC_A2 -> WB unconditionally; WB -> MAC_B1 (channel 1) after channel 0; WB -> IDLE after channel 1.
REQ-024 MAC_B1 SHALL load acc = B1*x; MAC_B2 SHALL add B2*x_prev; MAC_A2 SHALL subtract A2*y_prev; acc is signed and at least 38 bits.
REQ-025 WB SHALL compute y = acc >>> 15 (arithmetic, floor), saturate it to [-32768, 32767], write y to outN and y_prev, and write x to x_prev.
REQ-026 With tick in cycle T, out0 and out_valid[0] SHALL change at the edge ending cycle T+4; out1 and out_valid[1] SHALL change at the edge ending cycle T+8.
REQ-027 Each out_valid bit SHALL be high for exactly one clock per tick; outN SHALL hold its value between updates.
REQ-028 busy SHALL be high in cycles T+1..T+8 and low otherwise.
REQ-029 Because DIV >= 16, tick SHALL never occur while busy is high; no overrun handling is provided.
REQ-030 cfg_sel = 3 SHALL have no effect.

Reset
REQ-031 While reset = 0 at a clock edge: counter = 0, FSM = IDLE, busy = 0, out0 = out1 = 0, out_valid = 0, x_prev = y_prev = 0, acc = 0.
REQ-032 Reset SHALL load shadow and active coefficients of both channels with B1_DEF, B2_DEF and A2_DEF.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no out_valid pulse; the first tick after release SHALL occur DIV clocks after the release edge.

Verification
REQ-034 Hold reset 3 clocks -> all outputs 0 and busy = 0; first out_valid[0] 4 clocks after the first tick, out_valid[1] 4 clocks later.
REQ-035 Defaults, in0 = 16384 constant from reset -> out0 = 176 at the first tick, then 524 at the second, converging toward 16384 with no overshoot.
REQ-036 Write B1 = B2 = 32767 to channel 1, in1 = 32767 -> out1 = 32767 (saturated); in1 = -32768 -> out1 = -32768.
REQ-037 Write B1 = 0 to channel 0 while busy -> current sequence uses 352; the next tick uses 0; channel 1 unchanged.
REQ-038 Assert reset at cycle T+6 of a sequence -> out1 is not updated, out_valid stays 0, and outputs read 0.
REQ-039 in0 = -1, in1 = 1 for 100 ticks with defaults -> out0 settles at -1 and out1 settles at 0 (floor rounding); the outputs stay stable with no oscillation.
